keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
Scans a 4x4 matrix keypad. Drives one row low at a time, the same way the display driver multiplexes its anodes, and reads the column lines. Debounces the result over whole sweeps and emits one pulse per accepted key press, with the key's hex value. Keeps a 4-digit shift history (digits[15:0]) sized to drive the BCD_control digit inputs directly, so keypad entry can replace the switch/button digits on the display.

Parameters:
SCAN_DIV, 10000, clk cycles per row slot; must be >= 4; the default gives 10 kHz row rate at 100 MHz.
DEBOUNCE_SWEEPS, 4, consecutive identical full sweeps needed to accept a press or a release; range 1..15.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
col_in  input  4  keypad column lines, active-low, externally pulled up, asynchronous to clk
row_out  output  4  keypad row drive, active-low, exactly one bit low at any time
key_value  output  4  hex value of the last accepted key
key_valid  output  1  one-clk pulse when a key is accepted
key_held  output  1  high while the accepted key is still considered pressed
digits  output  16  last four accepted keys, newest in [3:0]

Behaviour:
- Reset values: row_out=4'b1110 (row 0), key_value=0, key_valid=0, key_held=0, digits=16'h0000, FSM=IDLE, all counters 0.
- Reset is asynchronous at any time, including mid-debounce; no key_valid may follow reset until a fresh full debounce completes.
- col_in passes through a 2-flop synchronizer before any use.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - tick is asserted when the count equals SCAN_DIV-1.
- Row index r (2 bits):
  - On tick, the synchronized columns are sampled for the current row, then r increments and wraps 3->0.
  - row_out = ~(1<<r).
- Sweep evaluation:
  - The tick at r=3 ends a sweep and produces a registered sweep_done pulse one clk later.
  - The sweep result is hit (any column low in any row) and code = {row,col} of the lowest-index pressed key, with row priority over column: r0c0 highest, r3c3 lowest.
- Keymap, code -> value:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: 0 F E D
- FSM acts only on sweep_done:
  - IDLE:
    - hit -> CONFIRM, cand=code, cnt=1.
    - If DEBOUNCE_SWEEPS=1, accept immediately.
  - CONFIRM:
    - hit and code==cand -> cnt+1; when cnt reaches DEBOUNCE_SWEEPS, accept.
    - hit and code!=cand -> stay in CONFIRM, cand=code, cnt=1.
    - no hit -> IDLE.
  - Accept:
    - FSM -> PRESSED.
    - key_value <= keymap(cand).
    - digits <= {digits[11:0], keymap(cand)}.
    - key_valid high for exactly the clk following the sweep_done cycle.
  - PRESSED:
    - key_held=1.
    - no hit -> RELEASE, cnt=1.
    - any hit -> stay.
    - No auto-repeat; a change to another key while held is ignored.
  - RELEASE:
    - key_held stays 1.
    - no hit -> cnt+1; at DEBOUNCE_SWEEPS -> IDLE and key_held=0.
    - hit -> PRESSED, with no new key_valid.
- Latency: key_valid occurs (DEBOUNCE_SWEEPS sweeps from the first sweep containing the key) + 2 clk after the final sweep's last tick.
- All outputs are registered; nothing is combinational from col_in.

Decomposition:
- keypad_pkg holds:
  - the FSM state enum (IDLE, CONFIRM, PRESSED, RELEASE)
  - the 16-entry KEYMAP constant
  - the ROWS/COLS=4 constants
- Sub-module keypad_row_scanner contains:
  - prescaler
  - row counter
  - synchronizer
  - per-sweep priority capture
- keypad_row_scanner outputs row_out, sweep_done, hit and code. The top holds the debounce FSM and the history register.

Test Plan:
- Bench settings: SCAN_DIV=4, DEBOUNCE_SWEEPS=3, so one sweep = 16 clk.
- The keypad model drives col_in[c]=0 when row_out[r]=0 and key (r,c) is pressed.
1. Reset -> row_out=1110 and cycles 1110,1101,1011,0111 every 4 clk; key_valid=0, digits=0000.
2. Hold r1c2 -> exactly one key_valid after the 3rd sweep; key_value=6, digits=0x0006, key_held=1; no further pulse across 10 held sweeps; after release, key_held falls after 3 empty sweeps.
3. Bounce:
   - Press r0c0 for 2 sweeps, release 1 sweep, press 2 sweeps -> no key_valid.
   - Then a 3rd consecutive sweep -> one pulse, value 1.
   - While held, 1 empty sweep then pressed again -> no second pulse.
4. Press r2c1 and r0c0 together -> key_value=1. Press r3c1 and r3c2 together -> key_value=F.
5. Enter 1,2,3,A, each held 4 sweeps and released 4 sweeps -> four pulses; digits=0x123A, key_value=A.
6. Assert reset mid-CONFIRM (after sweep 2 of a press) -> no key_valid, row_out=1110 immediately. Keep the key held -> pulse after 3 sweeps counted from reset release.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Key codes are {row, col}; KEYMAP converts a code into the printed hex legend.
package keypad_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONFIRM = 2'd1,
    PRESSED = 2'd2,
    RELEASE = 2'd3
  } key_state_e;

  // Element [code] is the legend of key {row, col}; entry 0 is listed last.
  localparam logic [15:0][3:0] KEYMAP = {
    4'hD, 4'hE, 4'hF, 4'h0,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

endpackage

// File: rtl/keypad_row_scanner.sv
// Row multiplexer for the keypad: prescaler, row counter, column synchronizer
// and a per-sweep capture of the highest-priority pressed key.
module keypad_row_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 10000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [COLS-1:0] col_in,
  output logic [ROWS-1:0] row_out,
  output logic            sweep_done,
  output logic            hit,
  output logic [3:0]      code
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0]   presc_q, presc_d;
  logic [1:0]      row_q, row_d;
  logic [ROWS-1:0] row_out_q, row_out_d;
  logic [COLS-1:0] sync1_q, sync2_q;
  logic            acc_hit_q, acc_hit_d;
  logic [3:0]      acc_code_q, acc_code_d;
  logic            done_q, done_d;
  logic            hit_q, hit_d;
  logic [3:0]      code_q, code_d;

  logic            tick;
  logic [COLS-1:0] col_pressed;
  logic [1:0]      col_idx;
  logic            new_hit;
  logic [3:0]      new_code;

  always_comb begin
    tick        = (presc_q == PW'(SCAN_DIV - 1));
    presc_d     = tick ? '0 : presc_q + 1'b1;
    col_pressed = ~sync2_q;

    col_idx = 2'd0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (col_pressed[c]) col_idx = 2'(c);
    end

    // Rows are visited in ascending order, so the first capture in a sweep wins.
    new_hit  = acc_hit_q;
    new_code = acc_code_q;
    if (!acc_hit_q && (|col_pressed)) begin
      new_hit  = 1'b1;
      new_code = {row_q, col_idx};
    end

    row_d      = row_q;
    acc_hit_d  = acc_hit_q;
    acc_code_d = acc_code_q;
    done_d     = 1'b0;
    hit_d      = hit_q;
    code_d     = code_q;

    if (tick) begin
      row_d      = row_q + 2'd1;
      acc_hit_d  = new_hit;
      acc_code_d = new_code;
      if (row_q == 2'd3) begin
        done_d     = 1'b1;
        hit_d      = new_hit;
        code_d     = new_code;
        acc_hit_d  = 1'b0;
        acc_code_d = 4'd0;
      end
    end

    row_out_d = ~(ROWS'(1) << row_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q    <= '0;
      row_q      <= 2'd0;
      row_out_q  <= 4'b1110;
      sync1_q    <= '1;
      sync2_q    <= '1;
      acc_hit_q  <= 1'b0;
      acc_code_q <= 4'd0;
      done_q     <= 1'b0;
      hit_q      <= 1'b0;
      code_q     <= 4'd0;
    end else begin
      presc_q    <= presc_d;
      row_q      <= row_d;
      row_out_q  <= row_out_d;
      sync1_q    <= col_in;
      sync2_q    <= sync1_q;
      acc_hit_q  <= acc_hit_d;
      acc_code_q <= acc_code_d;
      done_q     <= done_d;
      hit_q      <= hit_d;
      code_q     <= code_d;
    end
  end

  assign row_out    = row_out_q;
  assign sweep_done = done_q;
  assign hit        = hit_q;
  assign code       = code_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad front end: sweep-level debounce FSM, one key_valid pulse per press,
// and a four-digit history shaped to feed the display digit inputs.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 10000,
  parameter int DEBOUNCE_SWEEPS = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [COLS-1:0] col_in,
  output logic [ROWS-1:0] row_out,
  output logic [3:0]      key_value,
  output logic            key_valid,
  output logic            key_held,
  output logic [15:0]     digits
);

  localparam logic [3:0] DS = 4'(DEBOUNCE_SWEEPS);

  logic       sweep_done;
  logic       hit;
  logic [3:0] code;

  keypad_row_scanner #(
    .SCAN_DIV(SCAN_DIV)
  ) u_row_scanner (
    .clk       (clk),
    .reset     (reset),
    .col_in    (col_in),
    .row_out   (row_out),
    .sweep_done(sweep_done),
    .hit       (hit),
    .code      (code)
  );

  key_state_e  state_q, state_d;
  logic [3:0]  cand_q, cand_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  key_value_q, key_value_d;
  logic        key_valid_q, key_valid_d;
  logic        key_held_q, key_held_d;
  logic [15:0] digits_q, digits_d;

  logic        accept;
  logic [3:0]  accept_code;
  logic [3:0]  cnt_inc;

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_value_d = key_value_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    digits_d    = digits_q;
    accept      = 1'b0;
    accept_code = cand_q;
    cnt_inc     = cnt_q + 4'd1;

    if (sweep_done) begin
      case (state_q)
        IDLE: begin
          if (hit) begin
            cand_d = code;
            cnt_d  = 4'd1;
            if (DS == 4'd1) begin
              accept      = 1'b1;
              accept_code = code;
            end else begin
              state_d = CONFIRM;
            end
          end
        end
        CONFIRM: begin
          if (!hit) begin
            state_d = IDLE;
          end else if (code == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DS) accept = 1'b1;
          end else begin
            cand_d = code;
            cnt_d  = 4'd1;
          end
        end
        PRESSED: begin
          // A different key appearing while held is deliberately ignored.
          if (!hit) begin
            cnt_d = 4'd1;
            if (DS == 4'd1) begin
              state_d    = IDLE;
              key_held_d = 1'b0;
            end else begin
              state_d = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (hit) begin
            state_d = PRESSED;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == DS) begin
              state_d    = IDLE;
              key_held_d = 1'b0;
            end
          end
        end
        default: state_d = IDLE;
      endcase

      if (accept) begin
        state_d     = PRESSED;
        key_value_d = KEYMAP[accept_code];
        digits_d    = {digits_q[11:0], KEYMAP[accept_code]};
        key_valid_d = 1'b1;
        key_held_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cand_q      <= 4'd0;
      cnt_q       <= 4'd0;
      key_value_q <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      digits_q    <= 16'h0000;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_value_q <= key_value_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      digits_q    <= digits_d;
    end
  end

  assign key_value = key_value_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign digits    = digits_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed and randomized bench for keypad_scanner with a sweep-level key model
// and a sliding-window debounce reference.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DS       = 3;
  localparam int SWEEP    = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [3:0]  key_value;
  logic        key_valid;
  logic        key_held;
  logic [15:0] digits;

  logic [15:0] pressed;

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SWEEPS(DS)
  ) dut (
    .clk      (clk),
    .reset    (rst),
    .col_in   (col_in),
    .row_out  (row_out),
    .key_value(key_value),
    .key_valid(key_valid),
    .key_held (key_held),
    .digits   (digits)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key shorts its row drive onto its column.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row_out[r] && pressed[r*4+c]) col_in[c] = 1'b0;
      end
    end
  end

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int fail_cnt = 0;
  int pulses   = 0;

  int          kmap[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};
  int          hist[$];
  bit          m_held;
  bit          m_pend;
  logic [3:0]  m_value;
  logic [15:0] m_digits;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_held   = 1'b0;
    m_pend   = 1'b0;
    m_value  = 4'h0;
    m_digits = 16'h0000;
  endtask

  function automatic int first_key(input logic [15:0] keys);
    for (int i = 0; i < 16; i++) begin
      if (keys[i]) return i;
    end
    return -1;
  endfunction

  // A press (or release) is recognised when the last DS sweeps all agree.
  task automatic model_sweep(input logic [15:0] keys);
    int res;
    bit same;
    res = first_key(keys);
    hist.push_back(res);
    if (hist.size() > DS) void'(hist.pop_front());
    same = (hist.size() == DS);
    foreach (hist[i]) if (hist[i] != res) same = 1'b0;
    m_pend = 1'b0;
    if (!m_held && same && res >= 0) begin
      m_pend   = 1'b1;
      m_value  = 4'(kmap[res]);
      m_digits = {m_digits[11:0], m_value};
      m_held   = 1'b1;
    end else if (m_held && same && res < 0) begin
      m_held = 1'b0;
    end
  endtask

  task automatic run_sweep(input logic [15:0] keys);
    logic [3:0] exp_row;
    pressed = keys;
    for (int k = 1; k <= SWEEP; k++) begin
      @(negedge clk);
      exp_row = ~(4'b0001 << ((k / SCAN_DIV) % 4));
      if (key_valid) pulses++;
      check("row_out", 16'(row_out), 16'(exp_row));
      check("key_valid", 16'(key_valid), (k == 1) ? 16'(m_pend) : 16'h0);
      check("key_held", 16'(key_held), 16'(m_held));
      check("key_value", 16'(key_value), 16'(m_value));
      check("digits", digits, m_digits);
    end
    model_sweep(keys);
  endtask

  task automatic run_n(input logic [15:0] keys, input int n);
    for (int i = 0; i < n; i++) run_sweep(keys);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_row_out"}, 16'(row_out), 16'h000E);
    check({tag, "_key_valid"}, 16'(key_valid), 16'h0);
    check({tag, "_key_held"}, 16'(key_held), 16'h0);
    check({tag, "_key_value"}, 16'(key_value), 16'h0);
    check({tag, "_digits"}, digits, 16'h0000);
  endtask

  initial begin
    int n_part;
    int mode;
    int len;
    logic [15:0] keys;

    // 1: reset state and row rotation
    rst     = 1'b1;
    pressed = 16'h0000;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    run_n(16'h0000, 2);

    // 2: single key held, then released
    pulses = 0;
    run_n(16'h0040, 4);
    check("t2_value", 16'(key_value), 16'h0006);
    check("t2_digits", digits, 16'h0006);
    check("t2_held", 16'(key_held), 16'h1);
    run_n(16'h0040, 9);
    check("t2_pulses", 16'(pulses), 16'd1);
    run_n(16'h0000, 4);
    check("t2_released", 16'(key_held), 16'h0);

    // 3: bouncing contact
    pulses = 0;
    run_n(16'h0001, 2);
    run_n(16'h0000, 1);
    run_n(16'h0001, 2);
    check("t3_no_pulse", 16'(pulses), 16'd0);
    run_n(16'h0001, 2);
    check("t3_one_pulse", 16'(pulses), 16'd1);
    check("t3_value", 16'(key_value), 16'h0001);
    run_n(16'h0000, 1);
    run_n(16'h0001, 2);
    run_n(16'h0000, 4);
    check("t3_no_repeat", 16'(pulses), 16'd1);

    // 4: two keys at once, priority
    run_n((16'h1 << 9) | 16'h0001, 4);
    check("t4_prio_a", 16'(key_value), 16'h0001);
    run_n(16'h0000, 4);
    run_n((16'h1 << 13) | (16'h1 << 14), 4);
    check("t4_prio_b", 16'(key_value), 16'h000F);
    run_n(16'h0000, 4);

    // 5: enter 1 2 3 A
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      run_n(16'h1 << i, 4);
      run_n(16'h0000, 4);
    end
    check("t5_digits", digits, 16'h123A);
    check("t5_value", 16'(key_value), 16'h000A);
    check("t5_pulses", 16'(pulses), 16'd4);

    // 6: reset in the middle of confirmation
    pulses = 0;
    run_n(16'h0020, 2);
    n_part = $urandom_range(2, 14);
    for (int j = 0; j < n_part; j++) begin
      @(negedge clk);
      check("t6_pre_reset_valid", 16'(key_valid), 16'h0);
    end
    #2 rst = 1'b1;
    #1 check_reset_values("t6_reset");
    repeat (2) @(negedge clk);
    check_reset_values("t6_hold");
    rst = 1'b0;
    model_reset();
    run_n(16'h0020, 3);
    check("t6_no_early_pulse", 16'(pulses), 16'd0);
    run_n(16'h0020, 1);
    check("t6_pulse", 16'(pulses), 16'd1);
    check("t6_value", 16'(key_value), 16'h0005);
    run_n(16'h0000, 4);

    // 7: randomized key activity
    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 3);
      len  = $urandom_range(1, 5);
      keys = 16'h0000;
      if (mode == 1 || mode == 2) keys = 16'h1 << $urandom_range(0, 15);
      if (mode == 3) keys = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      run_n(keys, len);
    end
    run_n(16'h0000, 4);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
